// File: rtl/rv_writeback_if.sv
// Execute/data-memory to writeback bundle, plus the register-file write port.
// The slave modport is the writeback stage; the master is the pipeline/memory side.
interface rv_writeback_if;
    logic [2:0]  x_fun_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_rd_value_i;
    logic        x_rd_write_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        dm_store_done_i;
    logic        w_stall_req_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;

    modport slave (
        input  x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_value_i, x_rd_write_i,
        input  x_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
        output w_stall_req_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o
    );

    modport master (
        output x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_value_i, x_rd_write_i,
        output x_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
        input  w_stall_req_o, rf_rd_o, rf_rd_value_o, rf_rd_write_o
    );
endinterface

// File: rtl/rv_writeback.sv
// Writeback stage: completes loads/stores and issues one registered rf write per instruction.
// Latency: 1 cycle from capture (non-load) or from the cycle load-done is seen.
// Backpressure: combinational stall request while a data-memory access is incomplete.
module rv_writeback (
    input  logic           clk_i,
    input  logic           rst_n_i,
    rv_writeback_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_LOAD, S_WAIT_STORE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  fun_q;
    logic [4:0]  rd_q;
    logic        rd_write_q;
    logic [1:0]  addr_q;
    logic        lat_en;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_val;
    logic        unused_addr;

    assign unused_addr = ^bus.x_dm_addr_i[31:2];

    function automatic logic [31:0] load_fmt(input logic [2:0] fun, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (fun)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        lat_en    = 1'b0;
        wr_en     = 1'b0;
        wr_rd     = 5'd0;
        wr_val    = 32'd0;
        case (state)
            S_IDLE: begin
                if (bus.x_load_i) begin
                    // load wins over a simultaneous store
                    lat_en = 1'b1;
                    if (bus.dm_load_done_i) begin
                        wr_en  = bus.x_rd_write_i;
                        wr_rd  = bus.x_rd_i;
                        wr_val = load_fmt(bus.x_fun_i, bus.x_dm_addr_i[1:0], bus.dm_data_l_i);
                    end else begin
                        state_nxt = S_WAIT_LOAD;
                        stall     = 1'b1;
                    end
                end else if (bus.x_store_i) begin
                    if (!bus.dm_store_done_i) begin
                        state_nxt = S_WAIT_STORE;
                        stall     = 1'b1;
                    end
                end else if (bus.x_rd_write_i) begin
                    wr_en  = 1'b1;
                    wr_rd  = bus.x_rd_i;
                    wr_val = bus.x_rd_value_i;
                end
            end
            S_WAIT_LOAD: begin
                if (bus.dm_load_done_i) begin
                    wr_en     = rd_write_q;
                    wr_rd     = rd_q;
                    wr_val    = load_fmt(fun_q, addr_q, bus.dm_data_l_i);
                    state_nxt = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            S_WAIT_STORE: begin
                if (bus.dm_store_done_i) state_nxt = S_IDLE;
                else                     stall     = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.w_stall_req_o = rst_n_i & stall;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state             <= S_IDLE;
            fun_q             <= 3'd0;
            rd_q              <= 5'd0;
            rd_write_q        <= 1'b0;
            addr_q            <= 2'd0;
            bus.rf_rd_write_o <= 1'b0;
            bus.rf_rd_o       <= 5'd0;
            bus.rf_rd_value_o <= 32'd0;
        end else begin
            state             <= state_nxt;
            bus.rf_rd_write_o <= wr_en && (wr_rd != 5'd0);
            if (lat_en) begin
                fun_q      <= bus.x_fun_i;
                rd_q       <= bus.x_rd_i;
                rd_write_q <= bus.x_rd_write_i;
                addr_q     <= bus.x_dm_addr_i[1:0];
            end
            if (wr_en) begin
                bus.rf_rd_o       <= wr_rd;
                bus.rf_rd_value_o <= wr_val;
            end
        end
    end
endmodule

// File: doc/rv_writeback.md
# rv_writeback

Writeback stage of the uRV pipeline, directly downstream of the execute stage. It captures the registered execute results, waits for outstanding data-memory load/store completion, aligns and sign-extends load data, and issues a single registered register-file write per instruction. While a memory access is still pending it raises a stall request back to the pipeline.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- x_fun_i  in  3  funct3 of the instruction in writeback (load width/sign)
- x_load_i  in  1  instruction is a load; one-cycle pulse
- x_store_i  in  1  instruction is a store; one-cycle pulse
- x_rd_i  in  5  destination register index
- x_rd_value_i  in  32  ALU/shifter/CSR result for non-load writes
- x_rd_write_i  in  1  instruction writes rd; one-cycle pulse
- x_dm_addr_i  in  32  data-memory byte address (bits [1:0] used)
- dm_data_l_i  in  32  load data word from data memory
- dm_load_done_i  in  1  load data valid this cycle
- dm_store_done_i  in  1  store accepted this cycle
- w_stall_req_o  out  1  stall request to pipeline (combinational)
- rf_rd_o  out  5  register-file write index (registered)
- rf_rd_value_o  out  32  register-file write data (registered)
- rf_rd_write_o  out  1  register-file write enable (registered)

## Operation
- State machine: IDLE, WAIT_LOAD, WAIT_STORE.
- IDLE, x_load_i=1: latch x_fun_i, x_rd_i, x_rd_write_i, x_dm_addr_i[1:0]. If dm_load_done_i=1 same cycle: complete load (write next edge), stay IDLE. Else -> WAIT_LOAD.
- IDLE, x_store_i=1: dm_store_done_i=1 same cycle -> stay IDLE; else -> WAIT_STORE. Stores never write rf.
- IDLE, x_rd_write_i=1, no load: rf write of x_rd_value_i to x_rd_i on next edge.
- WAIT_LOAD: on dm_load_done_i=1 complete load from latched fields, -> IDLE. x_* inputs ignored in this state.
- WAIT_STORE: on dm_store_done_i=1 -> IDLE. x_* inputs ignored.
- x_load_i and x_store_i both 1: load takes priority, store ignored (protocol violation).
- Load formatting, offset a = latched addr[1:0]:
  - 000 LB: byte dm_data_l_i[8a+7:8a], sign-extended to 32.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at a[1] (bits [15:0] or [31:16]), sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: full word; a ignored.
  - other codes: value 0, write still performed if x_rd_write_i was latched.
- rd = 0: rf_rd_write_o forced 0 for any source.
- w_stall_req_o = (IDLE & x_load_i & !dm_load_done_i) | (IDLE & x_store_i & !x_load_i & !dm_store_done_i) | (WAIT_LOAD & !dm_load_done_i) | (WAIT_STORE & !dm_store_done_i). Forced 0 while rst_n_i=0.

## Timing
- Reset (rst_n_i=0 at edge): state IDLE; rf_rd_write_o=0, rf_rd_o=0, rf_rd_value_o=0. Reset mid-WAIT discards the pending access; no rf write ever issued for it.
- Non-load write latency: 1 cycle (capture edge N, rf_rd_write_o high during N+1 for exactly one cycle).
- Load latency: 1 cycle after the cycle dm_load_done_i is sampled high.
- rf_rd_write_o is a single-cycle pulse; deasserts next edge unless a new write completes.
- Stall request asserted in the same cycle the access is found incomplete, deasserted in the cycle done arrives (combinational), so the upstream releases on the completing edge.
- dm_load_done_i/dm_store_done_i high in IDLE with no access pending: ignored.

## Test plan
- Reset: hold rst_n_i=0 3 cycles with x_rd_write_i=1 -> rf_rd_write_o=0, rf_rd_value_o=0, w_stall_req_o=0; release -> first write appears 1 cycle after capture.
- ALU write: x_rd_i=5, x_rd_value_i=0x12345678, x_rd_write_i=1 -> next cycle rf_rd_o=5, value 0x12345678, write=1 one cycle; repeat with rd=0 -> write=0.
- Zero-wait loads: dm_data_l_i=0x80FF7F01, done same cycle; LB addr 3 -> 0xFFFFFF80; LBU addr 3 -> 0x00000080; LH addr 2 -> 0xFFFF80FF; LHU addr 0 -> 0x00007F01; LW -> 0x80FF7F01.
- Waited load: LW rd=7, done asserted 3 cycles later with data 0xDEADBEEF -> w_stall_req_o high 3 cycles, x_* pulses during wait ignored, rf write rd=7 value 0xDEADBEEF one cycle after done.
- Waited store: x_store_i with done 2 cycles later -> stall high 2 cycles, no rf write; simultaneous load+store -> treated as load only.
- Reset during WAIT_LOAD: assert rst_n_i=0 one cycle, then dm_load_done_i=1 -> no rf write, state IDLE, stall 0.
